// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the instruction-fetch (I) and data (D) ports.
// Define MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]   i_grant_cnt,
  output logic [15:0]   d_grant_cnt,
  output logic [15:0]   conflict_cnt,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_grant_d;
  logic       cur_d;
  logic       i_elig, d_elig;
  logic       grant_i, grant_d;
  logic       done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A port whose ready pulse is high this cycle is still holding its finished request.
  always_comb begin
    state_nxt = state;
    i_elig    = i_req & ~i_ready;
    d_elig    = d_req & ~d_ready;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        grant_d = d_elig & (~i_elig | ~last_grant_d);
        grant_i = i_elig & ~grant_d;
        if (grant_i | grant_d) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt == LAT) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= 4'd0;
      last_grant_d <= 1'b0;
      cur_d        <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
    end else begin
      mem_en  <= grant_i | grant_d;
      i_ready <= done & ~cur_d;
      d_ready <= done & cur_d;
      if (grant_i | grant_d) begin
        cnt          <= 4'd1;
        cur_d        <= grant_d;
        last_grant_d <= grant_d;
        mem_addr     <= grant_d ? d_addr : i_addr;
        mem_we       <= grant_d & d_we;
        if (grant_d) mem_wdata <= d_wdata;
      end else if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
      end
      if (done) begin
        if (cur_d) d_rdata <= mem_rdata;
        else       i_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_grant_cnt  <= 16'd0;
      d_grant_cnt  <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (grant_i && i_grant_cnt != 16'hFFFF) i_grant_cnt <= i_grant_cnt + 16'd1;
      if (grant_d && d_grant_cnt != 16'hFFFF) d_grant_cnt <= d_grant_cnt + 16'd1;
      if ((state == IDLE) && i_elig && d_elig && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LATENCY=2 instance for most scenarios and a LATENCY=1 instance
// for back-to-back throughput. Checks stats counters when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;

  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_ready, d_ready, mem_en, mem_we;
  logic        en_d1;

  logic        i_req1, d_req1, d_we1;
  logic [31:0] i_addr1, d_addr1, d_wdata1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        i_ready1, d_ready1, mem_en1, mem_we1;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] i_grant_cnt, d_grant_cnt, conflict_cnt;
  logic [15:0] i_grant_cnt1, d_grant_cnt1, conflict_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h4) ? 32'h20020005 : {a[15:0], 16'hC0DE};
  endfunction

  // Memory models: data is presented only in the cycle the arbiter is due to sample it.
  always @(posedge clk or negedge rst) begin
    if (!rst) en_d1 <= 1'b0;
    else      en_d1 <= mem_en;
  end
  assign mem_rdata  = en_d1   ? mem_word(mem_addr)  : 32'hDEADBEEF;
  assign mem_rdata1 = mem_en1 ? mem_word(mem_addr1) : 32'hDEADBEEF;

  mem_port_arbiter #(.LATENCY(2), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
`ifdef MEM_ARB_STATS_EN
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
`ifdef MEM_ARB_STATS_EN
    .i_grant_cnt(i_grant_cnt1), .d_grant_cnt(d_grant_cnt1), .conflict_cnt(conflict_cnt1),
`endif
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    i_req1 = 0; d_req1 = 0; d_we1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;

    // Reset state of both instances
    tick();
    check_output("rst mem_en",    32'(mem_en),    32'd0);
    check_output("rst mem_we",    32'(mem_we),    32'd0);
    check_output("rst mem_addr",  mem_addr,       32'd0);
    check_output("rst mem_wdata", mem_wdata,      32'd0);
    check_output("rst i_ready",   32'(i_ready),   32'd0);
    check_output("rst d_ready",   32'(d_ready),   32'd0);
    check_output("rst i_rdata",   i_rdata,        32'd0);
    check_output("rst d_rdata",   d_rdata,        32'd0);
    check_output("rst1 mem_en",   32'(mem_en1),   32'd0);
    check_output("rst1 mem_addr", mem_addr1,      32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single fetch; i_addr changes after grant and must be ignored
    tick();
    i_req = 1; i_addr = 32'h4;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output($sformatf("fetch c%0d mem_en", c),  32'(mem_en),  32'(c == 1));
      check_output($sformatf("fetch c%0d i_ready", c), 32'(i_ready), 32'(c == 3));
      check_output($sformatf("fetch c%0d d_ready", c), 32'(d_ready), 32'd0);
      if (c <= 2) check_output($sformatf("fetch c%0d mem_addr", c), mem_addr, 32'h4);
      if (c == 1) check_output("fetch mem_we", 32'(mem_we), 32'd0);
      if (c >= 3) check_output($sformatf("fetch c%0d i_rdata", c), i_rdata, 32'h20020005);
      if (c == 1) i_addr = 32'h100;
      if (c == 3) i_req = 0;
    end

    // Store; d_wdata changes after grant and must be ignored
    tick();
    d_req = 1; d_we = 1; d_addr = 32'd84; d_wdata = 32'd7;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output($sformatf("store c%0d mem_en", c),  32'(mem_en),  32'(c == 1));
      check_output($sformatf("store c%0d d_ready", c), 32'(d_ready), 32'(c == 3));
      check_output($sformatf("store c%0d i_ready", c), 32'(i_ready), 32'd0);
      if (c <= 2) begin
        check_output($sformatf("store c%0d mem_we", c),    32'(mem_we), 32'd1);
        check_output($sformatf("store c%0d mem_addr", c),  mem_addr,    32'd84);
        check_output($sformatf("store c%0d mem_wdata", c), mem_wdata,   32'd7);
      end
      if (c == 1) d_wdata = 32'd99;
      if (c == 3) begin d_req = 0; d_we = 0; end
    end

    // Load whose request drops after one cycle still completes, exactly once
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) d_req = 0;
      check_output($sformatf("drop c%0d mem_en", c),  32'(mem_en),  32'(c == 1));
      check_output($sformatf("drop c%0d d_ready", c), 32'(d_ready), 32'(c == 3));
      check_output($sformatf("drop c%0d i_ready", c), 32'(i_ready), 32'd0);
      check_output($sformatf("drop c%0d i_rdata", c), i_rdata,      32'h20020005);
      if (c == 3) check_output("drop d_rdata", d_rdata, 32'h0040C0DE);
    end

    // Reset one cycle after mem_en abandons the fetch
    tick();
    i_req = 1; i_addr = 32'h8;
    tick();
    check_output("midrst mem_en",   32'(mem_en), 32'd1);
    check_output("midrst mem_addr", mem_addr,    32'h8);
    tick();
    rst = 1'b0; i_req = 0;
    #1;
    check_output("midrst mem_addr0",  mem_addr,     32'd0);
    check_output("midrst mem_wdata0", mem_wdata,    32'd0);
    check_output("midrst mem_en0",    32'(mem_en),  32'd0);
    check_output("midrst i_rdata0",   i_rdata,      32'd0);
    check_output("midrst d_rdata0",   d_rdata,      32'd0);
    check_output("midrst i_ready0",   32'(i_ready), 32'd0);
    tick();
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_output($sformatf("postrst c%0d i_ready", c), 32'(i_ready), 32'd0);
      check_output($sformatf("postrst c%0d mem_en", c),  32'(mem_en),  32'd0);
    end

    // Both ports held after reset: D, I, D, I
    tick();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h10; d_addr = 32'h20;
    for (int c = 1; c <= 13; c++) begin
      tick();
      check_output($sformatf("conf c%0d mem_en", c),  32'(mem_en),  32'(c == 1 || c == 4 || c == 7 || c == 10));
      check_output($sformatf("conf c%0d d_ready", c), 32'(d_ready), 32'(c == 3 || c == 9));
      check_output($sformatf("conf c%0d i_ready", c), 32'(i_ready), 32'(c == 6 || c == 12));
      if (c == 1 || c == 7)  check_output($sformatf("conf c%0d mem_addr", c), mem_addr, 32'h20);
      if (c == 4 || c == 10) check_output($sformatf("conf c%0d mem_addr", c), mem_addr, 32'h10);
      if (c == 3) check_output("conf d_rdata", d_rdata, 32'h0020C0DE);
      if (c == 6) check_output("conf i_rdata", i_rdata, 32'h0010C0DE);
      if (c == 12) begin i_req = 0; d_req = 0; end
    end
`ifdef MEM_ARB_STATS_EN
    check_output("stats i_grant_cnt",  32'(i_grant_cnt),  32'd2);
    check_output("stats d_grant_cnt",  32'(d_grant_cnt),  32'd2);
    check_output("stats conflict_cnt", 32'(conflict_cnt), 32'd1);
`endif

    // Normal fetch after the mid-access reset
    tick();
    i_req = 1; i_addr = 32'h4;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_output($sformatf("refetch c%0d mem_en", c),  32'(mem_en),  32'(c == 1));
      check_output($sformatf("refetch c%0d i_ready", c), 32'(i_ready), 32'(c == 3));
      if (c == 3) begin
        check_output("refetch i_rdata", i_rdata, 32'h20020005);
        i_req = 0;
      end
    end

    // LATENCY=1: one access every two cycles with both ports held
    tick();
    i_req1 = 1; d_req1 = 1; i_addr1 = 32'h34; d_addr1 = 32'h30;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check_output($sformatf("lat1 c%0d mem_en", c),  32'(mem_en1),  32'(c == 1 || c == 3 || c == 5));
      check_output($sformatf("lat1 c%0d d_ready", c), 32'(d_ready1), 32'(c == 2 || c == 6));
      check_output($sformatf("lat1 c%0d i_ready", c), 32'(i_ready1), 32'(c == 4));
      if (c == 2) check_output("lat1 d_rdata", d_rdata1, 32'h0030C0DE);
      if (c == 4) check_output("lat1 i_rdata", i_rdata1, 32'h0034C0DE);
      if (c == 6) begin i_req1 = 0; d_req1 = 0; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
